dsram_arbiter: RTL and testbench
================================

Name: dsram_arbiter

Overview:
- Shares the single data-SRAM macro port between the core load/store unit and the Wishbone management path.
- Replaces the static select-bit mux with a pipelined arbiter:
  - fixed core priority, plus a bounded-starvation guarantee for management;
  - registered SRAM command outputs (active-low CE/WE);
  - read-return routing back to the requester that issued the read.
- Sits between the core/Wishbone slave logic and the SRAM macro pins in the user-project wrapper.

Parameters:
ADDR_W, 13, SRAM word-address width
DATA_W, 32, data width; the write mask is DATA_W/8 bits
RD_LAT, 2, cycles from issue cycle to the cycle rvalid is asserted (minimum 1)
MAX_WAIT, 4, consecutive cycles management may wait before it overrides core priority

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
mgmt_only  in  1  when 1, core is never granted (management owns the SRAM)
core_req  in  1  core request; held stable until granted
core_we  in  1  1=write, 0=read
core_addr  in  ADDR_W  word address
core_wdata  in  DATA_W  write data
core_wm  in  DATA_W/8  byte write mask
core_gnt  out  1  request accepted this cycle (combinational)
core_rvalid  out  1  one-cycle read-return strobe
core_rdata  out  DATA_W  read data, valid while core_rvalid=1
mgmt_req, mgmt_we, mgmt_addr, mgmt_wdata, mgmt_wm  in  as core  management request
mgmt_gnt, mgmt_rvalid  out  1  as core
mgmt_rdata  out  DATA_W  as core
sram_ce_n  out  1  SRAM chip enable, active low
sram_we_n  out  1  SRAM write enable, active low
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_wm  out  DATA_W/8  SRAM byte mask
sram_rdata  in  DATA_W  SRAM read data
busy  out  1  read pipeline non-empty or command issuing

Behaviour:
- Handshake and issue timing:
  - A request is accepted in cycle A when req=1 and gnt=1.
  - At most one acceptance per cycle; back-to-back acceptances are allowed (fully pipelined).
  - The accepted command is registered onto the sram_* outputs for exactly one cycle, the issue cycle I = A+1.
  - In cycle I, sram_ce_n=0; sram_we_n = !we.
  - In every non-issue cycle, sram_ce_n=1 and sram_we_n=1; addr/wdata/wm hold their last values.
- Grant rules, evaluated combinationally each cycle:
  - wb_rst_i=1: both gnt=0.
  - mgmt_only=1: core_gnt=0; mgmt_gnt = mgmt_req.
  - Only one requester active: that requester is granted.
  - Both active: core is granted, unless wait_cnt==MAX_WAIT, in which case mgmt is granted.
- wait_cnt (width clog2(MAX_WAIT+1)):
  - increments, saturating at MAX_WAIT, when mgmt_req && !mgmt_gnt;
  - clears to 0 when mgmt_gnt=1 or mgmt_req=0.
- Read return:
  - A shift pipeline of RD_LAT stages carries {valid, owner} for each issued read; writes insert a bubble.
  - The stage exiting at the end of cycle I+RD_LAT-1 captures sram_rdata into the owner's rdata register.
  - The owner's rvalid is asserted in cycle I+RD_LAT (i.e. A+1+RD_LAT), for one cycle.
  - With the default RD_LAT=2: accept cycle A gives rvalid in cycle A+3.
  - Return order equals issue order. A non-owner's rdata is unchanged.
- busy = any pipeline stage valid, or an issue in progress.
- Reset values (wb_rst_i=1 at an edge):
  - sram_ce_n=1, sram_we_n=1, sram_addr=0, sram_wdata=0, sram_wm=0;
  - core_rvalid=0, mgmt_rvalid=0, core_rdata=0, mgmt_rdata=0;
  - wait_cnt=0; pipeline cleared; busy=0.
- Reset mid-operation:
  - In-flight reads are dropped: no rvalid is produced for any read accepted before reset.
  - A command registered in the same cycle as reset is not issued.
- mgmt_only toggling:
  - Takes effect on grants in the same cycle.
  - In-flight reads still return to their recorded owner.
- Write-then-read to the same address in consecutive acceptances:
  - The read observes the new data; the SRAM processes commands in order, and no bypass is required.

Test Plan:
- Core-only read: core_req=1, we=0, addr=0x012 at A=5 -> sram_ce_n=0, sram_we_n=1, sram_addr=0x012 in cycle 6; sram_rdata=0xDEADBEEF driven in cycle 7 -> core_rvalid=1, core_rdata=0xDEADBEEF in cycle 8 only; mgmt_rvalid stays 0.
- Write: mgmt_req=1, we=1, addr=0x1FFF, wdata=0xA5A5_0000, wm=4'b1100 -> one cycle of ce_n=0, we_n=0 with those values; no rvalid on either port.
- Contention and starvation: core_req and mgmt_req held high continuously, MAX_WAIT=4 -> core granted 4 cycles, mgmt granted on the 5th, wait_cnt back to 0; pattern repeats every 5 cycles.
- mgmt_only=1 with both requesting -> core_gnt=0 every cycle and mgmt_gnt=1; set mgmt_only=0 mid-burst -> core granted that same cycle; a pending mgmt read still returns on mgmt_rvalid.
- Pipelined reads: alternating core/mgmt reads accepted in cycles 10, 11, 12 -> rvalid in cycles 13 (core), 14 (mgmt), 15 (core), each carrying the matching sram_rdata.
- Reset mid-flight: read accepted at cycle 20, wb_rst_i=1 in cycle 21 -> no rvalid in cycles 22-25; all outputs at their reset values; busy=0 after the reset edge.

Source files
------------

// File: rtl/dsram_arbiter.sv
// Data-SRAM port arbiter: core-priority grants with bounded management
// starvation, registered SRAM command and owner-tagged read return.
module dsram_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                mgmt_only,
    input  logic                core_req,
    input  logic                core_we,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    input  logic [DATA_W/8-1:0] core_wm,
    output logic                core_gnt,
    output logic                core_rvalid,
    output logic [DATA_W-1:0]   core_rdata,
    input  logic                mgmt_req,
    input  logic                mgmt_we,
    input  logic [ADDR_W-1:0]   mgmt_addr,
    input  logic [DATA_W-1:0]   mgmt_wdata,
    input  logic [DATA_W/8-1:0] mgmt_wm,
    output logic                mgmt_gnt,
    output logic                mgmt_rvalid,
    output logic [DATA_W-1:0]   mgmt_rdata,
    output logic                sram_ce_n,
    output logic                sram_we_n,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    output logic [DATA_W/8-1:0] sram_wm,
    input  logic [DATA_W-1:0]   sram_rdata,
    output logic                busy
);
    localparam int WM_W = DATA_W / 8;
    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MAX_WAIT);

    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              issue_q, issue_d;
    logic              we_n_q, we_n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [WM_W-1:0]   wm_q, wm_d;
    logic [RD_LAT-1:0] pipe_v_q, pipe_v_d;
    logic [RD_LAT-1:0] pipe_o_q, pipe_o_d;
    logic              core_rvalid_q, core_rvalid_d;
    logic              mgmt_rvalid_q, mgmt_rvalid_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] mgmt_rdata_q, mgmt_rdata_d;

    logic              acc;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [WM_W-1:0]   acc_wm;

    always_comb begin
        core_gnt = 1'b0;
        mgmt_gnt = 1'b0;
        if (!wb_rst_i) begin
            if (mgmt_only) begin
                mgmt_gnt = mgmt_req;
            end else if (core_req && mgmt_req) begin
                // management overrides only once it has waited MAX_WAIT cycles
                if (wait_cnt_q == WAIT_MAX) mgmt_gnt = 1'b1;
                else                        core_gnt = 1'b1;
            end else begin
                core_gnt = core_req;
                mgmt_gnt = mgmt_req;
            end
        end
    end

    always_comb begin
        acc       = core_gnt | mgmt_gnt;
        acc_we    = mgmt_gnt ? mgmt_we    : core_we;
        acc_addr  = mgmt_gnt ? mgmt_addr  : core_addr;
        acc_wdata = mgmt_gnt ? mgmt_wdata : core_wdata;
        acc_wm    = mgmt_gnt ? mgmt_wm    : core_wm;
    end

    always_comb begin
        wait_cnt_d = '0;
        if (mgmt_req && !mgmt_gnt) begin
            if (wait_cnt_q == WAIT_MAX) wait_cnt_d = wait_cnt_q;
            else                        wait_cnt_d = wait_cnt_q + WC_W'(1);
        end

        issue_d = acc;
        we_n_d  = acc ? !acc_we : 1'b1;
        addr_d  = acc ? acc_addr  : addr_q;
        wdata_d = acc ? acc_wdata : wdata_q;
        wm_d    = acc ? acc_wm    : wm_q;

        // stage 0 is the issue cycle; writes travel as bubbles
        pipe_v_d    = '0;
        pipe_o_d    = '0;
        pipe_v_d[0] = acc && !acc_we;
        pipe_o_d[0] = mgmt_gnt;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_v_d[i] = pipe_v_q[i-1];
            pipe_o_d[i] = pipe_o_q[i-1];
        end

        core_rvalid_d = pipe_v_q[RD_LAT-1] && !pipe_o_q[RD_LAT-1];
        mgmt_rvalid_d = pipe_v_q[RD_LAT-1] &&  pipe_o_q[RD_LAT-1];
        core_rdata_d  = core_rvalid_d ? sram_rdata : core_rdata_q;
        mgmt_rdata_d  = mgmt_rvalid_d ? sram_rdata : mgmt_rdata_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wait_cnt_q    <= '0;
            issue_q       <= 1'b0;
            we_n_q        <= 1'b1;
            addr_q        <= '0;
            wdata_q       <= '0;
            wm_q          <= '0;
            pipe_v_q      <= '0;
            pipe_o_q      <= '0;
            core_rvalid_q <= 1'b0;
            mgmt_rvalid_q <= 1'b0;
            core_rdata_q  <= '0;
            mgmt_rdata_q  <= '0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            issue_q       <= issue_d;
            we_n_q        <= we_n_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wm_q          <= wm_d;
            pipe_v_q      <= pipe_v_d;
            pipe_o_q      <= pipe_o_d;
            core_rvalid_q <= core_rvalid_d;
            mgmt_rvalid_q <= mgmt_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            mgmt_rdata_q  <= mgmt_rdata_d;
        end
    end

    assign sram_ce_n   = !issue_q;
    assign sram_we_n   = we_n_q;
    assign sram_addr   = addr_q;
    assign sram_wdata  = wdata_q;
    assign sram_wm     = wm_q;
    assign core_rvalid = core_rvalid_q;
    assign mgmt_rvalid = mgmt_rvalid_q;
    assign core_rdata  = core_rdata_q;
    assign mgmt_rdata  = mgmt_rdata_q;
    assign busy        = issue_q | (|pipe_v_q);

endmodule

// File: tb/tb_dsram_arbiter.sv
// Bench for dsram_arbiter: directed scenarios then random traffic,
// all checked against a cycle-indexed transaction model.
module tb_dsram_arbiter;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int RD_LAT = 2;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          wb_rst_i, mgmt_only;
    logic          core_req, core_we, mgmt_req, mgmt_we;
    logic [AW-1:0] core_addr, mgmt_addr;
    logic [DW-1:0] core_wdata, mgmt_wdata;
    logic [3:0]    core_wm, mgmt_wm;
    logic          core_gnt, mgmt_gnt, core_rvalid, mgmt_rvalid;
    logic [DW-1:0] core_rdata, mgmt_rdata;
    logic          sram_ce_n, sram_we_n, busy;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic [3:0]    sram_wm;

    always #5 clk = ~clk;

    dsram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .mgmt_only(mgmt_only),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_wm(core_wm), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .mgmt_req(mgmt_req), .mgmt_we(mgmt_we), .mgmt_addr(mgmt_addr),
        .mgmt_wdata(mgmt_wdata), .mgmt_wm(mgmt_wm), .mgmt_gnt(mgmt_gnt),
        .mgmt_rvalid(mgmt_rvalid), .mgmt_rdata(mgmt_rdata),
        .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_wm(sram_wm), .sram_rdata(sram_rdata), .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int          cyc = 0;
    bit          armed = 0;
    int          waited = 0;
    bit          iss_v = 0, iss_we = 0;
    logic [AW-1:0] l_addr = '0;
    logic [DW-1:0] l_wdata = '0;
    logic [3:0]  l_wm = '0;
    logic [DW-1:0] m_crd = '0, m_mrd = '0, prev_rd = '0;
    int          q_due[$];
    bit          q_own[$];
    bit          c_hold = 0, m_hold = 0;
    int          n_mgnt_contend = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        bit eg_c, eg_m, erc, erm, ebusy;
        @(negedge clk);
        eg_c = 0;
        eg_m = 0;
        if (wb_rst_i) begin
        end else if (mgmt_only) begin
            eg_m = mgmt_req;
        end else if (core_req && mgmt_req) begin
            if (waited >= MAX_WAIT) eg_m = 1;
            else                    eg_c = 1;
        end else begin
            eg_c = core_req;
            eg_m = mgmt_req;
        end
        if (armed) begin
            chk("core_gnt", 64'(core_gnt), 64'(eg_c));
            chk("mgmt_gnt", 64'(mgmt_gnt), 64'(eg_m));
            chk("ce_n", 64'(sram_ce_n), 64'(!iss_v));
            chk("we_n", 64'(sram_we_n), 64'(!(iss_v && iss_we)));
            chk("addr", 64'(sram_addr), 64'(l_addr));
            chk("wdata", 64'(sram_wdata), 64'(l_wdata));
            chk("wm", 64'(sram_wm), 64'(l_wm));
            erc = 0;
            erm = 0;
            if (q_due.size() > 0 && q_due[0] == cyc) begin
                if (q_own[0]) begin m_mrd = prev_rd; erm = 1; end
                else          begin m_crd = prev_rd; erc = 1; end
                void'(q_due.pop_front());
                void'(q_own.pop_front());
            end
            chk("core_rvalid", 64'(core_rvalid), 64'(erc));
            chk("mgmt_rvalid", 64'(mgmt_rvalid), 64'(erm));
            chk("core_rdata", 64'(core_rdata), 64'(m_crd));
            chk("mgmt_rdata", 64'(mgmt_rdata), 64'(m_mrd));
            ebusy = iss_v;
            foreach (q_due[i])
                if (q_due[i] - RD_LAT <= cyc && cyc < q_due[i]) ebusy = 1;
            chk("busy", 64'(busy), 64'(ebusy));
        end
        if (core_req && mgmt_req && !mgmt_only && eg_m) n_mgnt_contend++;
        // state update at the end of this cycle
        if (wb_rst_i) begin
            armed = 1;
            waited = 0;
            iss_v = 0;
            iss_we = 0;
            l_addr = '0;
            l_wdata = '0;
            l_wm = '0;
            m_crd = '0;
            m_mrd = '0;
            q_due.delete();
            q_own.delete();
        end else begin
            iss_v = eg_c | eg_m;
            if (iss_v) begin
                iss_we  = eg_m ? mgmt_we    : core_we;
                l_addr  = eg_m ? mgmt_addr  : core_addr;
                l_wdata = eg_m ? mgmt_wdata : core_wdata;
                l_wm    = eg_m ? mgmt_wm    : core_wm;
                if (!iss_we) begin
                    q_due.push_back(cyc + 1 + RD_LAT);
                    q_own.push_back(eg_m);
                end
            end
            if (mgmt_req && !eg_m) waited = (waited < MAX_WAIT) ? waited + 1 : MAX_WAIT;
            else                   waited = 0;
        end
        c_hold = core_req && !eg_c;
        m_hold = mgmt_req && !eg_m;
        prev_rd = sram_rdata;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        wb_rst_i = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 39) == 0) mgmt_only = ~mgmt_only;
        if (!c_hold) begin
            core_req   = ($urandom_range(0, 99) < 60);
            core_we    = $urandom_range(0, 1) == 1;
            core_addr  = AW'($urandom);
            core_wdata = $urandom;
            core_wm    = 4'($urandom);
        end
        if (!m_hold) begin
            mgmt_req   = ($urandom_range(0, 99) < 50);
            mgmt_we    = $urandom_range(0, 1) == 1;
            mgmt_addr  = AW'($urandom);
            mgmt_wdata = $urandom;
            mgmt_wm    = 4'($urandom);
        end
        sram_rdata = $urandom;
    endtask

    initial begin
        wb_rst_i = 1; mgmt_only = 0;
        core_req = 0; core_we = 0; core_addr = '0;
        core_wdata = '0; core_wm = '0;
        mgmt_req = 0; mgmt_we = 0; mgmt_addr = '0;
        mgmt_wdata = '0; mgmt_wm = '0;
        sram_rdata = '0;
        #1;
        step(); step();
        wb_rst_i = 0;
        step();

        // core-only read
        core_req = 1; core_we = 0; core_addr = 13'h012;
        sram_rdata = 32'hDEADBEEF;
        step();
        core_req = 0;
        repeat (4) step();

        // management write
        mgmt_req = 1; mgmt_we = 1; mgmt_addr = 13'h1FFF;
        mgmt_wdata = 32'hA5A5_0000; mgmt_wm = 4'b1100;
        step();
        mgmt_req = 0;
        repeat (3) step();

        // sustained contention
        n_mgnt_contend = 0;
        core_req = 1; core_we = 0; core_addr = 13'h0AA;
        mgmt_req = 1; mgmt_we = 0; mgmt_addr = 13'h155;
        for (int i = 0; i < 15; i++) begin
            sram_rdata = $urandom;
            step();
        end
        chk("starve_cnt", 64'(n_mgnt_contend), 64'd3);

        // mgmt_only, then released mid-burst
        mgmt_only = 1;
        repeat (4) begin sram_rdata = $urandom; step(); end
        mgmt_only = 0;
        repeat (2) begin sram_rdata = $urandom; step(); end
        core_req = 0; mgmt_req = 0;
        repeat (5) begin sram_rdata = $urandom; step(); end

        // reset with a read in flight
        core_req = 1; core_we = 0; core_addr = 13'h033;
        step();
        core_req = 0; wb_rst_i = 1;
        step();
        wb_rst_i = 0;
        repeat (5) begin sram_rdata = $urandom; step(); end

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end
        wb_rst_i = 0; core_req = 0; mgmt_req = 0;
        c_hold = 0; m_hold = 0;
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
